// File: rtl/spi_seq_pkg.sv
// Shared types and constants for the SPI transaction sequencer.
package spi_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD_CTRL = 3'd1,
        ST_WAIT_CTRL = 3'd2,
        ST_LOAD_DATA = 3'd3,
        ST_WAIT_DATA = 3'd4,
        ST_FINISH    = 3'd5
    } spi_seq_state_t;

    localparam logic MUX_SEL_CTRL = 1'b0;
    localparam logic MUX_SEL_DATA = 1'b1;

    localparam int unsigned TIMEOUT_CYCLES_DFLT = 1024;

endpackage

// File: rtl/module_spi_seq_timeout.sv
// Watchdog for the sequencer wait states: cleared before each wait,
// counts wait cycles and flags expiry on the TIMEOUT_CYCLES-th one.
module module_spi_seq_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_c
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            cnt_q <= '0;
        end else if (en_i && !expired_c) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign expired_c = en_i && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/module_spi_seq_ctrl.sv
// SPI transaction sequencer: control word then N data words through the
// external 2:1 mux. Optional watchdog/err_o under SPI_SEQ_TIMEOUT_EN.
module module_spi_seq_ctrl
    import spi_seq_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 5,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DFLT
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  send_i,
    input  logic [ADDR_WIDTH-1:0] n_words_i,
    input  logic                  shift_done_i,
    output logic                  mux_sel_o,
    output logic                  load_o,
    output logic                  cs_n_o,
    output logic [ADDR_WIDTH-1:0] rd_addr_o,
    output logic                  wr_en_o,
    output logic [ADDR_WIDTH-1:0] wr_addr_o,
    output logic                  busy_o,
    output logic                  done_o
`ifdef SPI_SEQ_TIMEOUT_EN
    ,
    output logic                  err_o
`endif
);

    spi_seq_state_t        state;
    logic [ADDR_WIDTH-1:0] n_q;
    logic [ADDR_WIDTH-1:0] idx;
    logic [ADDR_WIDTH-1:0] idx_inc;

    assign idx_inc = idx + ADDR_WIDTH'(1);

    // Word width and watchdog limit only matter outside this block / with the macro.
    if (DATA_WIDTH == 0 || TIMEOUT_CYCLES == 0) begin : g_unsupported_cfg
    end

`ifdef SPI_SEQ_TIMEOUT_EN
    logic timeout_c;

    module_spi_seq_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clr_i    ((state == ST_LOAD_CTRL) || (state == ST_LOAD_DATA)),
        .en_i     ((state == ST_WAIT_CTRL) || (state == ST_WAIT_DATA)),
        .expired_c(timeout_c)
    );
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= ST_IDLE;
            n_q       <= '0;
            idx       <= '0;
            mux_sel_o <= MUX_SEL_CTRL;
            load_o    <= 1'b0;
            cs_n_o    <= 1'b1;
            rd_addr_o <= '0;
            wr_en_o   <= 1'b0;
            wr_addr_o <= '0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
`ifdef SPI_SEQ_TIMEOUT_EN
            err_o     <= 1'b0;
`endif
        end else begin
            load_o  <= 1'b0;
            wr_en_o <= 1'b0;
            done_o  <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (send_i) begin
                        state     <= ST_LOAD_CTRL;
                        n_q       <= n_words_i;
                        idx       <= '0;
                        cs_n_o    <= 1'b0;
                        mux_sel_o <= MUX_SEL_CTRL;
                        rd_addr_o <= '0;
                        load_o    <= 1'b1;
                        busy_o    <= 1'b1;
`ifdef SPI_SEQ_TIMEOUT_EN
                        err_o     <= 1'b0;
`endif
                    end
                end

                ST_LOAD_CTRL: state <= ST_WAIT_CTRL;

                // Control-phase receive data is dropped; no write strobe.
                ST_WAIT_CTRL: begin
                    if (shift_done_i) begin
                        if (n_q == '0) begin
                            state     <= ST_FINISH;
                            cs_n_o    <= 1'b1;
                            done_o    <= 1'b1;
                            mux_sel_o <= MUX_SEL_CTRL;
                        end else begin
                            state     <= ST_LOAD_DATA;
                            mux_sel_o <= MUX_SEL_DATA;
                            rd_addr_o <= idx;
                            load_o    <= 1'b1;
                        end
                    end
`ifdef SPI_SEQ_TIMEOUT_EN
                    else if (timeout_c) begin
                        state     <= ST_FINISH;
                        cs_n_o    <= 1'b1;
                        done_o    <= 1'b1;
                        mux_sel_o <= MUX_SEL_CTRL;
                        err_o     <= 1'b1;
                    end
`endif
                end

                ST_LOAD_DATA: state <= ST_WAIT_DATA;

                ST_WAIT_DATA: begin
                    if (shift_done_i) begin
                        wr_en_o   <= 1'b1;
                        wr_addr_o <= idx;
                        idx       <= idx_inc;
                        if (idx_inc == n_q) begin
                            state     <= ST_FINISH;
                            cs_n_o    <= 1'b1;
                            done_o    <= 1'b1;
                            mux_sel_o <= MUX_SEL_CTRL;
                        end else begin
                            state     <= ST_LOAD_DATA;
                            rd_addr_o <= idx_inc;
                            load_o    <= 1'b1;
                        end
                    end
`ifdef SPI_SEQ_TIMEOUT_EN
                    else if (timeout_c) begin
                        state     <= ST_FINISH;
                        cs_n_o    <= 1'b1;
                        done_o    <= 1'b1;
                        mux_sel_o <= MUX_SEL_CTRL;
                        err_o     <= 1'b1;
                    end
`endif
                end

                ST_FINISH: begin
                    state  <= ST_IDLE;
                    busy_o <= 1'b0;
                end

                default: begin
                    state     <= ST_IDLE;
                    cs_n_o    <= 1'b1;
                    mux_sel_o <= MUX_SEL_CTRL;
                    busy_o    <= 1'b0;
                end
            endcase
        end
    end

endmodule
